ifd_prefetch_unit: RTL and testbench

- Parametrised successor to the single-request PDP-8 fetch/decode front end.
- Keeps up to MEM_LATENCY reads in flight and buffers fetched words in a QUEUE_DEPTH-entry prefetch queue.
- Presents the head instruction with a light pre-decode to the execution unit.
- Supports PC redirect with flush of queued and in-flight fetches, and stops fetching after a HLT is issued.

---
 rtl/ifd_prefetch_unit.sv | 177 +++++++++++++++++
 tb/tb_ifd_prefetch_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifd_prefetch_unit.sv
// ifd_prefetch_unit
// Instruction fetch front end with a prefetch queue. Keeps up to MEM_LATENCY
// reads in flight, buffers returned words in a QUEUE_DEPTH-entry queue and
// presents the head word with a light PDP-8 pre-decode.
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   stall               execution unit busy, holds the queue head
//   redirect_valid/pc   restart fetching at redirect_pc, flushing everything
//   ifu_rd_req/addr     registered memory read request
//   ifu_rd_data         read data, sampled MEM_LATENCY cycles after the request
//   instr_*             head instruction, its address and pre-decode bits
//   queue_count         occupied queue entries
//   done                a HLT was issued and fetching has stopped
module ifd_prefetch_unit #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 12,
    parameter int QUEUE_DEPTH = 4,
    parameter int MEM_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic                           redirect_valid,
    input  logic [ADDR_WIDTH-1:0]          redirect_pc,
    output logic                           ifu_rd_req,
    output logic [ADDR_WIDTH-1:0]          ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0]          ifu_rd_data,
    output logic                           instr_valid,
    output logic [DATA_WIDTH-1:0]          instr_data,
    output logic [ADDR_WIDTH-1:0]          instr_pc,
    output logic [2:0]                     instr_opcode,
    output logic                           instr_is_mem,
    output logic                           instr_is_op7,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           done
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = $clog2(QUEUE_DEPTH + MEM_LATENCY + 2) + 1;
    localparam logic [DATA_WIDTH-1:0] HLT_WORD = DATA_WIDTH'(12'o7402);

    typedef enum logic {RUN, HALTED} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic                    epoch;
    logic [DATA_WIDTH-1:0]   q_data [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count;

    // Stage 0 is loaded on the issuing edge; stage MEM_LATENCY lines up with
    // the edge at which the matching ifu_rd_data is sampled.
    logic                    pipe_valid [MEM_LATENCY+1];
    logic                    pipe_epoch [MEM_LATENCY+1];
    logic [ADDR_WIDTH-1:0]   pipe_pc    [MEM_LATENCY+1];

    logic                    pop;
    logic                    hlt_pop;
    logic                    rsp_write;
    logic                    issue;
    logic [SUM_W-1:0]        in_flight;

    assign queue_count  = count;
    assign instr_valid  = (count != '0) && !done;
    assign instr_data   = q_data[head];
    assign instr_pc     = q_pc[head];
    assign instr_opcode = instr_data[DATA_WIDTH-1:DATA_WIDTH-3];
    assign instr_is_mem = (instr_opcode < 3'd6);
    assign instr_is_op7 = (instr_opcode == 3'd7);

    assign pop       = instr_valid && !stall && !redirect_valid;
    assign hlt_pop   = pop && (instr_data == HLT_WORD);
    assign rsp_write = pipe_valid[MEM_LATENCY] && (pipe_epoch[MEM_LATENCY] == epoch)
                       && !redirect_valid && !hlt_pop;

    // Every valid pipeline stage, including the one returning this edge, holds
    // a credit; a pop on the same edge hands one credit back.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= MEM_LATENCY; i++) begin
            in_flight = in_flight + SUM_W'(pipe_valid[i]);
        end
    end

    // A HLT being popped stops fetching on that very edge, so nothing is
    // requested after the halting instruction leaves the queue.
    assign issue = !done && !redirect_valid && !hlt_pop &&
                   ((SUM_W'(count) + in_flight) < (SUM_W'(QUEUE_DEPTH) + SUM_W'(pop)));

    // Fetch state machine, request outputs, response pipeline and queue.
    // Flushes also clear the pipeline valids so that a 1-bit epoch can never
    // alias with a response left over from two flushes ago.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            done        <= 1'b0;
            fetch_pc    <= START_ADDR;
            epoch       <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            ifu_rd_req  <= 1'b0;
            ifu_rd_addr <= START_ADDR;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
            for (int i = 0; i <= MEM_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_epoch[i] <= 1'b0;
                pipe_pc[i]    <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_epoch[0] <= epoch;
            pipe_pc[0]    <= fetch_pc;
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_epoch[i] <= pipe_epoch[i-1];
                pipe_pc[i]    <= pipe_pc[i-1];
            end

            ifu_rd_req <= issue;
            if (issue) begin
                ifu_rd_addr <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end

            if (redirect_valid) begin
                state    <= RUN;
                done     <= 1'b0;
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                for (int i = 1; i <= MEM_LATENCY; i++) begin
                    pipe_valid[i] <= 1'b0;
                end
            end else if (hlt_pop) begin
                state <= HALTED;
                done  <= 1'b1;
                epoch <= ~epoch;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int i = 1; i <= MEM_LATENCY; i++) begin
                    pipe_valid[i] <= 1'b0;
                end
            end else begin
                if (rsp_write) begin
                    q_data[tail] <= ifu_rd_data;
                    q_pc[tail]   <= pipe_pc[MEM_LATENCY];
                    tail         <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (rsp_write && !pop) begin
                    count <= count + 1'b1;
                end else if (!rsp_write && pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // The credit scheme keeps a response from ever landing in a full queue.
    assert property (@(posedge clk) disable iff (!reset_n)
                     !(rsp_write && !pop && (count == CNT_W'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_ifd_prefetch_unit.sv
// tb_ifd_prefetch_unit
// Drives three prefetch units (MEM_LATENCY 1, 2 and 3) from shared stimulus.
// Each unit has its own memory model returning mem[addr] MEM_LATENCY cycles
// after the request is sampled. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_ifd_prefetch_unit;

    localparam int NI = 3;
    localparam logic [11:0] HLT = 12'o7402;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              stall = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [11:0]       redirect_pc = 12'o0;

    logic [NI-1:0]        rd_req;
    logic [NI-1:0][11:0]  rd_addr;
    logic [NI-1:0][11:0]  rd_data;
    logic [NI-1:0]        iv;
    logic [NI-1:0][11:0]  idata;
    logic [NI-1:0][11:0]  ipc;
    logic [NI-1:0][2:0]   iop;
    logic [NI-1:0]        ismem;
    logic [NI-1:0]        isop7;
    logic [NI-1:0][2:0]   qcnt;
    logic [NI-1:0]        done_o;

    logic [11:0] mem [4096];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // One unit per latency, each with a memory that returns the requested
    // word through a latency-long delay line.
    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [11:0] stage [g+1];

        ifd_prefetch_unit #(
            .ADDR_WIDTH (12),
            .DATA_WIDTH (12),
            .QUEUE_DEPTH(4),
            .MEM_LATENCY(g + 1),
            .START_ADDR (12'o200)
        ) u_dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .stall         (stall),
            .redirect_valid(redirect_valid),
            .redirect_pc   (redirect_pc),
            .ifu_rd_req    (rd_req[g]),
            .ifu_rd_addr   (rd_addr[g]),
            .ifu_rd_data   (rd_data[g]),
            .instr_valid   (iv[g]),
            .instr_data    (idata[g]),
            .instr_pc      (ipc[g]),
            .instr_opcode  (iop[g]),
            .instr_is_mem  (ismem[g]),
            .instr_is_op7  (isop7[g]),
            .queue_count   (qcnt[g]),
            .done          (done_o[g])
        );

        always @(posedge clk) begin
            stage[0] <= rd_req[g] ? mem[rd_addr[g]] : 12'bx;
            for (int k = 1; k <= g; k++) stage[k] <= stage[k-1];
        end
        assign rd_data[g] = stage[g];
    end

    // Random memory image that never contains a HLT.
    task automatic fill_mem;
        logic [11:0] w;
        for (int i = 0; i < 4096; i++) begin
            w = 12'($urandom_range(0, 4095));
            if (w == HLT) w = 12'o7400;
            mem[i] = w;
        end
    endtask

    // Returns at a falling edge with reset just released; the next rising
    // edge is the first one with reset_n high.
    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 12'o0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        fill_mem();
        @(negedge clk);
        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++; if (rd_req[g] !== 1'b0) begin errors++; $display("[TB] FAIL reset_req inst%0d got %b want 0", g, rd_req[g]); end
            checks++; if (rd_addr[g] !== 12'o200) begin errors++; $display("[TB] FAIL reset_addr inst%0d got %o want 200", g, rd_addr[g]); end
            checks++; if (done_o[g] !== 1'b0) begin errors++; $display("[TB] FAIL reset_done inst%0d got %b want 0", g, done_o[g]); end
            checks++; if (iv[g] !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid inst%0d got %b want 0", g, iv[g]); end
            checks++; if (qcnt[g] !== 3'd0) begin errors++; $display("[TB] FAIL reset_count inst%0d got %0d want 0", g, qcnt[g]); end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic_fetch;
        int n;
        fill_mem();
        mem[12'o200] = 12'o1200;
        mem[12'o201] = 12'o3201;
        do_reset();
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++; if (rd_req[g] !== 1'b1 || rd_addr[g] !== 12'o200) begin errors++; $display("[TB] FAIL first_req inst%0d got req=%b addr=%o want 1/200", g, rd_req[g], rd_addr[g]); end
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++; if (rd_req[g] !== 1'b1 || rd_addr[g] !== 12'o201) begin errors++; $display("[TB] FAIL second_req inst%0d got req=%b addr=%o want 1/201", g, rd_req[g], rd_addr[g]); end
        end
        n = 0;
        while (iv[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checks++; if (iv[0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_timeout got %b want 1", iv[0]); end
        checks++; if (idata[0] !== 12'o1200 || ipc[0] !== 12'o200) begin errors++; $display("[TB] FAIL basic_head0 got %o@%o want 1200@200", idata[0], ipc[0]); end
        checks++; if (ismem[0] !== 1'b1 || iop[0] !== 3'd1) begin errors++; $display("[TB] FAIL basic_decode0 got mem=%b op=%0d want 1/1", ismem[0], iop[0]); end
        @(negedge clk);
        checks++; if (iv[0] !== 1'b1 || idata[0] !== 12'o3201 || ipc[0] !== 12'o201) begin errors++; $display("[TB] FAIL basic_head1 got v=%b %o@%o want 1 3201@201", iv[0], idata[0], ipc[0]); end
    endtask

    task automatic test_stall_fill;
        int n_issue [NI];
        fill_mem();
        do_reset();
        stall = 1'b1;
        for (int g = 0; g < NI; g++) n_issue[g] = 0;
        repeat (14) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (rd_req[g] === 1'b1) begin
                    checks++; if (rd_addr[g] !== 12'(12'o200 + n_issue[g])) begin errors++; $display("[TB] FAIL stall_addr inst%0d got %o want %o", g, rd_addr[g], 12'(12'o200 + n_issue[g])); end
                    n_issue[g]++;
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            checks++; if (n_issue[g] != 4) begin errors++; $display("[TB] FAIL stall_issue_count inst%0d got %0d want 4", g, n_issue[g]); end
            checks++; if (rd_req[g] !== 1'b0 || qcnt[g] !== 3'd4) begin errors++; $display("[TB] FAIL stall_full inst%0d got req=%b count=%0d want 0/4", g, rd_req[g], qcnt[g]); end
            checks++; if (iv[g] !== 1'b1 || ipc[g] !== 12'o200) begin errors++; $display("[TB] FAIL stall_head inst%0d got v=%b pc=%o want 1/200", g, iv[g], ipc[g]); end
        end
        stall = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++; if (rd_req[g] !== 1'b1 || rd_addr[g] !== 12'o204) begin errors++; $display("[TB] FAIL resume_req inst%0d got req=%b addr=%o want 1/204", g, rd_req[g], rd_addr[g]); end
            checks++; if (ipc[g] !== 12'o201 || qcnt[g] !== 3'd3) begin errors++; $display("[TB] FAIL resume_pop inst%0d got pc=%o count=%0d want 201/3", g, ipc[g], qcnt[g]); end
        end
    endtask

    task automatic test_redirect_inflight;
        logic        seen [NI];
        logic [11:0] fpc  [NI];
        logic [11:0] fdat [NI];
        fill_mem();
        do_reset();
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 12'o400;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int g = 0; g < NI; g++) begin
            checks++; if (qcnt[g] !== 3'd0 || iv[g] !== 1'b0 || rd_req[g] !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush inst%0d got count=%0d v=%b req=%b want 0/0/0", g, qcnt[g], iv[g], rd_req[g]); end
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++; if (rd_req[g] !== 1'b1 || rd_addr[g] !== 12'o400) begin errors++; $display("[TB] FAIL redir_req inst%0d got req=%b addr=%o want 1/400", g, rd_req[g], rd_addr[g]); end
            seen[g] = 1'b0; fpc[g] = 12'o0; fdat[g] = 12'o0;
        end
        repeat (12) begin
            for (int g = 0; g < NI; g++) begin
                if (iv[g] === 1'b1 && !seen[g]) begin seen[g] = 1'b1; fpc[g] = ipc[g]; fdat[g] = idata[g]; end
            end
            @(negedge clk);
        end
        for (int g = 0; g < NI; g++) begin
            checks++; if (!seen[g] || fpc[g] !== 12'o400 || fdat[g] !== mem[12'o400]) begin errors++; $display("[TB] FAIL redir_first inst%0d got seen=%b %o@%o want %o@400", g, seen[g], fdat[g], fpc[g], mem[12'o400]); end
        end
    endtask

    task automatic test_wrap;
        logic [11:0] exp_seq [3];
        logic [11:0] ilog [NI][3];
        logic [11:0] plog [NI][3];
        int ni [NI];
        int np [NI];
        exp_seq[0] = 12'o7776; exp_seq[1] = 12'o7777; exp_seq[2] = 12'o0000;
        fill_mem();
        do_reset();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 12'o7776;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int g = 0; g < NI; g++) begin ni[g] = 0; np[g] = 0; end
        repeat (20) begin
            for (int g = 0; g < NI; g++) begin
                if (rd_req[g] === 1'b1 && ni[g] < 3) begin ilog[g][ni[g]] = rd_addr[g]; ni[g]++; end
                if (iv[g] === 1'b1 && np[g] < 3) begin plog[g][np[g]] = ipc[g]; np[g]++; end
            end
            @(negedge clk);
        end
        for (int g = 0; g < NI; g++) begin
            checks++; if (ni[g] != 3 || np[g] != 3) begin errors++; $display("[TB] FAIL wrap_counts inst%0d got issues=%0d pops=%0d want 3/3", g, ni[g], np[g]); end
            for (int k = 0; k < 3; k++) begin
                if (k < ni[g]) begin checks++; if (ilog[g][k] !== exp_seq[k]) begin errors++; $display("[TB] FAIL wrap_addr inst%0d #%0d got %o want %o", g, k, ilog[g][k], exp_seq[k]); end end
                if (k < np[g]) begin checks++; if (plog[g][k] !== exp_seq[k]) begin errors++; $display("[TB] FAIL wrap_pc inst%0d #%0d got %o want %o", g, k, plog[g][k], exp_seq[k]); end end
            end
        end
    endtask

    task automatic test_hlt;
        logic [11:0] last_pc  [NI];
        logic [11:0] last_dat [NI];
        int bad_req [NI];
        fill_mem();
        mem[12'o202] = HLT;
        do_reset();
        for (int g = 0; g < NI; g++) begin last_pc[g] = 12'o0; last_dat[g] = 12'o0; bad_req[g] = 0; end
        repeat (25) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (iv[g] === 1'b1) begin last_pc[g] = ipc[g]; last_dat[g] = idata[g]; end
                if (done_o[g] === 1'b1 && rd_req[g] !== 1'b0) bad_req[g]++;
            end
        end
        for (int g = 0; g < NI; g++) begin
            checks++; if (last_pc[g] !== 12'o202 || last_dat[g] !== HLT) begin errors++; $display("[TB] FAIL hlt_last_pop inst%0d got %o@%o want 7402@202", g, last_dat[g], last_pc[g]); end
            checks++; if (done_o[g] !== 1'b1 || iv[g] !== 1'b0 || qcnt[g] !== 3'd0) begin errors++; $display("[TB] FAIL hlt_state inst%0d got done=%b v=%b count=%0d want 1/0/0", g, done_o[g], iv[g], qcnt[g]); end
            checks++; if (bad_req[g] != 0 || rd_req[g] !== 1'b0) begin errors++; $display("[TB] FAIL hlt_no_fetch inst%0d got %0d late requests want 0", g, bad_req[g]); end
        end
        redirect_valid = 1'b1; redirect_pc = 12'o200;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int g = 0; g < NI; g++) begin
            checks++; if (done_o[g] !== 1'b0 || rd_req[g] !== 1'b0) begin errors++; $display("[TB] FAIL hlt_redir_clear inst%0d got done=%b req=%b want 0/0", g, done_o[g], rd_req[g]); end
        end
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++; if (rd_req[g] !== 1'b1 || rd_addr[g] !== 12'o200) begin errors++; $display("[TB] FAIL hlt_restart inst%0d got req=%b addr=%o want 1/200", g, rd_req[g], rd_addr[g]); end
        end
    endtask

    task automatic test_same_cycle;
        logic        hist [NI][10];
        logic        seen [NI];
        logic [11:0] fpc  [NI];
        logic [11:0] fdat [NI];
        fill_mem();
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) hist[g][c] = rd_req[g];
        end
        // Units 0 and 1 stream one word per cycle, so a response arrives and a
        // pop is pending on the redirect edge.
        for (int g = 0; g < 2; g++) begin
            checks++; if (hist[g][8-g-1] !== 1'b1 || iv[g] !== 1'b1) begin errors++; $display("[TB] FAIL same_setup inst%0d got req=%b v=%b want 1/1", g, hist[g][8-g-1], iv[g]); end
        end
        redirect_valid = 1'b1; redirect_pc = 12'o600;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int g = 0; g < NI; g++) begin
            checks++; if (qcnt[g] !== 3'd0 || iv[g] !== 1'b0) begin errors++; $display("[TB] FAIL same_flush inst%0d got count=%0d v=%b want 0/0", g, qcnt[g], iv[g]); end
            seen[g] = 1'b0; fpc[g] = 12'o0; fdat[g] = 12'o0;
        end
        repeat (12) begin
            for (int g = 0; g < NI; g++) begin
                if (iv[g] === 1'b1 && !seen[g]) begin seen[g] = 1'b1; fpc[g] = ipc[g]; fdat[g] = idata[g]; end
            end
            @(negedge clk);
        end
        for (int g = 0; g < NI; g++) begin
            checks++; if (!seen[g] || fpc[g] !== 12'o600 || fdat[g] !== mem[12'o600]) begin errors++; $display("[TB] FAIL same_first inst%0d got seen=%b %o@%o want %o@600", g, seen[g], fdat[g], fpc[g], mem[12'o600]); end
        end
    endtask

    task automatic test_reset_midstream;
        logic        seen [NI];
        logic [11:0] fpc  [NI];
        fill_mem();
        do_reset();
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            checks++; if (rd_req[g] !== 1'b0 || rd_addr[g] !== 12'o200 || qcnt[g] !== 3'd0 || iv[g] !== 1'b0) begin errors++; $display("[TB] FAIL midreset inst%0d got req=%b addr=%o count=%0d v=%b want 0/200/0/0", g, rd_req[g], rd_addr[g], qcnt[g], iv[g]); end
            seen[g] = 1'b0; fpc[g] = 12'o0;
        end
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (iv[g] === 1'b1 && !seen[g]) begin seen[g] = 1'b1; fpc[g] = ipc[g]; end
            end
        end
        for (int g = 0; g < NI; g++) begin
            checks++; if (!seen[g] || fpc[g] !== 12'o200) begin errors++; $display("[TB] FAIL midreset_first inst%0d got seen=%b pc=%o want 200", g, seen[g], fpc[g]); end
        end
    endtask

    // Reference model: the issue stream and the popped stream each follow a
    // program counter that counts up by one and jumps to redirect_pc; every
    // popped word must be the memory word at that address.
    task automatic test_random;
        logic [11:0] exp_issue [NI];
        logic [11:0] exp_pop   [NI];
        logic [11:0] ew;
        logic        s, r;
        logic [11:0] rpc;
        fill_mem();
        do_reset();
        for (int g = 0; g < NI; g++) begin exp_issue[g] = 12'o200; exp_pop[g] = 12'o200; end
        repeat (400) begin
            for (int g = 0; g < NI; g++) begin
                if (rd_req[g] === 1'b1) begin
                    checks++; if (rd_addr[g] !== exp_issue[g]) begin errors++; $display("[TB] FAIL rnd_issue inst%0d got %o want %o", g, rd_addr[g], exp_issue[g]); end
                    exp_issue[g] = exp_issue[g] + 12'd1;
                end
                checks++; if (done_o[g] !== 1'b0 || iv[g] !== (qcnt[g] != 3'd0) || qcnt[g] > 3'd4) begin errors++; $display("[TB] FAIL rnd_status inst%0d got done=%b v=%b count=%0d", g, done_o[g], iv[g], qcnt[g]); end
            end
            s   = ($urandom_range(0, 99) < 30);
            r   = ($urandom_range(0, 99) < 6);
            rpc = 12'($urandom_range(0, 4095));
            stall = s; redirect_valid = r; redirect_pc = rpc;
            for (int g = 0; g < NI; g++) begin
                if (iv[g] === 1'b1 && !s && !r) begin
                    ew = mem[exp_pop[g]];
                    checks++; if (ipc[g] !== exp_pop[g] || idata[g] !== ew) begin errors++; $display("[TB] FAIL rnd_pop inst%0d got %o@%o want %o@%o", g, idata[g], ipc[g], ew, exp_pop[g]); end
                    checks++; if (iop[g] !== ew[11:9] || ismem[g] !== (ew[11:9] < 3'd6) || isop7[g] !== (ew[11:9] == 3'd7)) begin errors++; $display("[TB] FAIL rnd_decode inst%0d got op=%0d mem=%b op7=%b for word %o", g, iop[g], ismem[g], isop7[g], ew); end
                    exp_pop[g] = exp_pop[g] + 12'd1;
                end
                if (r) begin exp_pop[g] = rpc; exp_issue[g] = rpc; end
            end
            @(negedge clk);
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_fill();
        test_redirect_inflight();
        test_wrap();
        test_hlt();
        test_same_cycle();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
